// File: rtl/rgbw_pwm_gen_if.sv
// Duty/load/tick inputs and PWM outputs of the RGBW PWM generator, grouped as one bundle.
interface rgbw_pwm_gen_if;
   logic       clk_en;
   logic [7:0] duty0;
   logic [7:0] duty1;
   logic [7:0] duty2;
   logic [7:0] duty3;
   logic       load;
   logic       d0;
   logic       d1;
   logic       d2;
   logic       d3;
   logic       period_start;
   logic       pending;

   modport master (
      output clk_en, duty0, duty1, duty2, duty3, load,
      input  d0, d1, d2, d3, period_start, pending
   );

   modport slave (
      input  clk_en, duty0, duty1, duty2, duty3, load,
      output d0, d1, d2, d3, period_start, pending
   );
endinterface

// File: rtl/rgbw_pwm_gen.sv
// Four-channel RGBW PWM, 255-tick period, duties double-buffered onto the period boundary.
// Latency: one clk from cnt/act to pin; no backpressure, load is a fire-and-forget strobe.
module rgbw_pwm_gen #(
   parameter int unsigned PHASE_STEP = 0
) (
   input logic           clk,
   input logic           reset,
   rgbw_pwm_gen_if.slave bus
);

   localparam int unsigned NCH = 4;

   // Per-channel phase offsets, already reduced modulo the 255-tick period.
   localparam logic [8:0] OFF [NCH] = '{
      9'd0,
      9'((1 * PHASE_STEP) % 255),
      9'((2 * PHASE_STEP) % 255),
      9'((3 * PHASE_STEP) % 255)
   };

   logic [7:0]     cnt;
   logic [7:0]     act  [NCH];
   logic [7:0]     pend [NCH];
   logic [7:0]     duty [NCH];
   logic [NCH-1:0] d_q;
   logic [NCH-1:0] d_nxt;
   logic           pending_q;
   logic           period_start_q;
   logic           wrap;

   assign duty[0] = bus.duty0;
   assign duty[1] = bus.duty1;
   assign duty[2] = bus.duty2;
   assign duty[3] = bus.duty3;

   assign wrap = bus.clk_en && (cnt == 8'd254);

   always_comb begin
      logic [8:0] sum;
      sum   = '0;
      d_nxt = '0;
      for (int i = 0; i < NCH; i++) begin
         sum = {1'b0, cnt} + OFF[i];
         if (sum >= 9'd255) begin
            sum = sum - 9'd255;
         end
         d_nxt[i] = (sum < {1'b0, act[i]});
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt            <= '0;
         pending_q      <= 1'b0;
         period_start_q <= 1'b0;
         d_q            <= '0;
         for (int i = 0; i < NCH; i++) begin
            act[i]  <= '0;
            pend[i] <= '0;
         end
      end else begin
         if (bus.clk_en) begin
            cnt <= (cnt == 8'd254) ? 8'd0 : cnt + 8'd1;
         end
         period_start_q <= wrap;
         d_q            <= d_nxt;

         if (bus.load) begin
            for (int i = 0; i < NCH; i++) begin
               pend[i] <= duty[i];
            end
         end

         // A load landing on the wrap edge goes straight to act so it is not lost for a period.
         if (wrap && bus.load) begin
            for (int i = 0; i < NCH; i++) begin
               act[i] <= duty[i];
            end
            pending_q <= 1'b0;
         end else if (wrap) begin
            if (pending_q) begin
               for (int i = 0; i < NCH; i++) begin
                  act[i] <= pend[i];
               end
            end
            pending_q <= 1'b0;
         end else if (bus.load) begin
            pending_q <= 1'b1;
         end
      end
   end

   assign bus.d0           = d_q[0];
   assign bus.d1           = d_q[1];
   assign bus.d2           = d_q[2];
   assign bus.d3           = d_q[3];
   assign bus.period_start = period_start_q;
   assign bus.pending      = pending_q;

endmodule

// File: tb/tb_rgbw_pwm_gen.sv
// Directed bench for rgbw_pwm_gen: aligned instance with clk_en every 4th clk, staggered instance free-running.
module tb_rgbw_pwm_gen;

   logic clk = 1'b0;
   logic reset;

   rgbw_pwm_gen_if a ();
   rgbw_pwm_gen_if b ();

   rgbw_pwm_gen #(.PHASE_STEP(0))  u_dut (.clk(clk), .reset(reset), .bus(a));
   rgbw_pwm_gen #(.PHASE_STEP(64)) u_stg (.clk(clk), .reset(reset), .bus(b));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int m_cnt;
   int hi [4];
   int ps_n;
   int pend_any;
   int pend_last;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_duty(input int v0, input int v1, input int v2, input int v3);
      a.duty0 = 8'(v0);
      a.duty1 = 8'(v1);
      a.duty2 = 8'(v2);
      a.duty3 = 8'(v3);
   endtask

   task automatic sample_a();
      hi[0]     += int'(a.d0);
      hi[1]     += int'(a.d1);
      hi[2]     += int'(a.d2);
      hi[3]     += int'(a.d3);
      ps_n      += int'(a.period_start);
      pend_any  |= int'(a.pending);
      pend_last  = int'(a.pending);
   endtask

   // One PWM tick: four clks, clk_en on the last; load optionally on the first or on the enabled clk.
   task automatic tick(input bit ld_first, input bit ld_en);
      for (int k = 0; k < 4; k++) begin
         a.clk_en = (k == 3);
         a.load   = (ld_first && k == 0) || (ld_en && k == 3);
         cyc();
         sample_a();
      end
      a.clk_en = 1'b0;
      a.load   = 1'b0;
      m_cnt    = (m_cnt == 254) ? 0 : m_cnt + 1;
   endtask

   // A full 255-tick window starting with cnt at 0; each high tick shows up as 4 high clks.
   task automatic run_period(input int ld_cnt, input bit ld_en);
      hi        = '{default: 0};
      ps_n      = 0;
      pend_any  = 0;
      pend_last = 0;
      for (int i = 0; i < 255; i++) begin
         tick(i == ld_cnt && !ld_en, i == ld_cnt && ld_en);
      end
   endtask

   task automatic check_win(input string tag, input int e0, input int e1, input int e2, input int e3,
                            input int e_pany, input int e_plast);
      chk({tag, "_h0"}, hi[0], e0);
      chk({tag, "_h1"}, hi[1], e1);
      chk({tag, "_h2"}, hi[2], e2);
      chk({tag, "_h3"}, hi[3], e3);
      chk({tag, "_ps"}, ps_n, 1);
      chk({tag, "_pany"}, pend_any, e_pany);
      chk({tag, "_plast"}, pend_last, e_plast);
   endtask

   initial begin
      int rise [4];
      int shi  [4];
      logic [3:0] prev;
      logic [3:0] cur;

      // Reset with load and clk_en asserted: reset must win.
      reset    = 1'b1;
      a.clk_en = 1'b1;
      a.load   = 1'b1;
      set_duty(99, 99, 99, 99);
      b.clk_en = 1'b0;
      b.load   = 1'b0;
      b.duty0  = 8'd0;
      b.duty1  = 8'd0;
      b.duty2  = 8'd0;
      b.duty3  = 8'd0;
      repeat (3) cyc();
      chk("rst_d", int'({a.d3, a.d2, a.d1, a.d0}), 0);
      chk("rst_ps", int'(a.period_start), 0);
      chk("rst_pend", int'(a.pending), 0);
      chk("rst_cnt", int'(u_dut.cnt), 0);
      reset    = 1'b0;
      a.clk_en = 1'b0;
      a.load   = 1'b0;
      m_cnt    = 0;

      // Load basic and extreme duties; act stays 0 for the rest of this period.
      set_duty(128, 0, 255, 50);
      run_period(10, 1'b0);
      check_win("w0", 0, 0, 0, 0, 1, 0);
      run_period(-1, 1'b0);
      check_win("w1", 512, 0, 1020, 200, 0, 0);
      run_period(-1, 1'b0);
      check_win("w2", 512, 0, 1020, 200, 0, 0);

      // Deferred update of duty3 from 50 to 200 at cnt=100.
      set_duty(128, 0, 255, 200);
      run_period(100, 1'b0);
      check_win("w3", 512, 0, 1020, 200, 1, 0);

      // Load on the wrap edge with duty0=10.
      set_duty(10, 0, 255, 200);
      run_period(254, 1'b1);
      check_win("w4", 512, 0, 1020, 800, 0, 0);

      set_duty(200, 200, 200, 200);
      run_period(50, 1'b0);
      check_win("w5", 40, 0, 1020, 800, 1, 0);
      run_period(-1, 1'b0);
      check_win("w6", 800, 800, 800, 800, 0, 0);

      // Reset at cnt=150 with all duties 200 and a further load still pending.
      set_duty(30, 30, 30, 30);
      for (int i = 0; i < 150; i++) begin
         tick(i == 120, 1'b0);
      end
      chk("pre_rst_d0", int'(a.d0), 1);
      chk("pre_rst_pend", int'(a.pending), 1);
      reset    = 1'b1;
      a.clk_en = 1'b1;
      a.load   = 1'b1;
      cyc();
      reset    = 1'b0;
      a.clk_en = 1'b0;
      a.load   = 1'b0;
      m_cnt    = 0;
      chk("mid_rst_d", int'({a.d3, a.d2, a.d1, a.d0}), 0);
      chk("mid_rst_cnt", int'(u_dut.cnt), 0);
      chk("mid_rst_pend", int'(a.pending), 0);
      chk("mid_rst_ps", int'(a.period_start), 0);
      run_period(-1, 1'b0);
      check_win("w8", 0, 0, 0, 0, 0, 0);
      run_period(-1, 1'b0);
      check_win("w9", 0, 0, 0, 0, 0, 0);

      // Staggered instance, clk_en tied high, all duties 64.
      b.duty0 = 8'd64;
      b.duty1 = 8'd64;
      b.duty2 = 8'd64;
      b.duty3 = 8'd64;
      b.load  = 1'b1;
      cyc();
      b.load  = 1'b0;
      chk("stg_pend_set", int'(b.pending), 1);
      b.clk_en = 1'b1;
      repeat (255) cyc();
      chk("stg_ps_first", int'(b.period_start), 1);
      chk("stg_pend_clr", int'(b.pending), 0);
      prev = {b.d3, b.d2, b.d1, b.d0};
      chk("stg_prev", int'(prev), 0);
      rise = '{default: -1};
      shi  = '{default: 0};
      for (int k = 0; k < 255; k++) begin
         cyc();
         cur = {b.d3, b.d2, b.d1, b.d0};
         for (int ch = 0; ch < 4; ch++) begin
            if (cur[ch] && !prev[ch]) rise[ch] = k;
            shi[ch] += int'(cur[ch]);
         end
         prev = cur;
      end
      chk("stg_rise0", rise[0], 0);
      chk("stg_rise1", rise[1], 191);
      chk("stg_rise2", rise[2], 127);
      chk("stg_rise3", rise[3], 63);
      chk("stg_hi0", shi[0], 64);
      chk("stg_hi1", shi[1], 64);
      chk("stg_hi2", shi[2], 64);
      chk("stg_hi3", shi[3], 64);
      chk("stg_ps_second", int'(b.period_start), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rgbw_pwm_gen.md
Name: rgbw_pwm_gen

Overview:
- Four-channel PWM generator for the R, G, B and W LED drivers.
- Sits downstream of the colour/deserializer path and consumes its four 8-bit duty values.
- Runs on the system clock, advancing on the clock-enable tick from the shared prescaler.
- Duties are double-buffered so a new set is applied only on a period boundary, which prevents glitched partial periods.

Parameters:
PHASE_STEP, 0, per-channel phase offset in ticks. Channel i is shifted by i*PHASE_STEP, modulo 255. 0 means all channels are aligned; 64 staggers their edges to reduce inrush.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
clk_en  in  1  PWM tick from the prescaler; the counter advances only on clk cycles where it is high
duty0  in  8  red duty, 0..255
duty1  in  8  green duty
duty2  in  8  blue duty
duty3  in  8  white duty
load  in  1  one-clk strobe; captures duty0..3 into the pending buffer
d0  out  1  red PWM output, registered
d1  out  1  green PWM output, registered
d2  out  1  blue PWM output, registered
d3  out  1  white PWM output, registered
period_start  out  1  one-clk pulse at the start of each PWM period
pending  out  1  high while loaded duties are waiting for a period boundary

Behaviour:
- Reset:
  - All of cnt, act0..3, pend0..3, pending, d0..d3 and period_start are 0 on the reset edge.
  - Reset overrides load and clk_en in the same cycle.
- Counter:
  - 8-bit cnt runs 0..254, so one period is 255 ticks.
  - On a clk edge with clk_en high: cnt <= (cnt==254) ? 0 : cnt+1.
  - cnt holds when clk_en is low.
- Wrap event: wrap = clk_en && cnt==254.
- Phase per channel:
  - ph_i = cnt + off_i, with off_i = (i*PHASE_STEP) mod 255.
  - If the 9-bit sum is >= 255, subtract 255.
  - All arithmetic is 9-bit, with no overflow.
- Output:
  - Every clk, d_i <= (ph_i < act_i), evaluated on the current cnt and act_i.
  - This gives one clk of latency from cnt to pin.
  - Duty 0 gives d_i always low. Duty 255 gives d_i always high.
  - Duty N gives exactly N high ticks per 255-tick period.
- Load:
  - On a load edge with no wrap: pend_i <= duty_i and pending <= 1.
  - act_i is unchanged, so the current period completes with the old duty.
  - A repeated load before the next wrap overwrites pend_i; the last load wins.
- Wrap:
  - On a wrap edge, if pending: act_i <= pend_i and pending <= 0.
  - Otherwise act_i holds.
- Load and wrap in the same cycle:
  - act_i <= duty_i directly, bypassing pend_i.
  - pend_i <= duty_i.
  - pending <= 0.
- period_start:
  - Registered as period_start <= wrap.
  - It is high for exactly the one clk following the wrap edge, i.e. while cnt==0 is first valid.
- clk_en stuck low: the outputs are static at the values for the current cnt and act_i. A load still sets pending.
- clk_en tied high: the block is valid as a free-running PWM at clk/255.
- Reset mid-period: outputs drop to 0 on the next clk edge. After reset, the first period starts at cnt=0 with act=0 until a load and wrap occur.

Test Plan:
- Basic duty: reset, clk_en high every 4th clk, load duty0=128, run 3 periods. Required: after the first wrap, d0 is high for exactly 128 ticks and low for 127, and period_start pulses once per 255 ticks.
- Extremes: load duty1=0 and duty2=255. Required: after the wrap, d1 stays 0 and d2 stays 1 continuously, and both hold across wraps with no glitch.
- Deferred update: with duty3=50 active, load duty3=200 at cnt=100. Required: pending=1, the current period stays at 50 high ticks, the next period has 200, and pending clears on the wrap edge.
- Load coincident with wrap: assert load on the clk where cnt==254 and clk_en is high, with duty0=10. Required: the very next period has 10 high ticks, and pending stays 0.
- Stagger: PHASE_STEP=64, all duties 64. Required: d0 rises at cnt=0, d1 rises 64 ticks before d0 (at cnt=191), d2 at cnt=127, d3 at cnt=63, and each is high for 64 ticks.
- Reset mid-operation: assert reset at cnt=150 with all duties 200. Required: the next clk gives d0..3=0, cnt=0, pending=0, and the outputs stay low until a load and wrap occur.
